arb_pattern_engine: RTL
=======================

# arb_pattern_engine

Parametrised, single-clock pattern sequencer core for the next-generation arbitrary pattern generator. It replays a stored NUM_SIG-wide pattern onto `output_signals` with a programmable per-sample hold time, loop length and repeat mode. It captures `input_signals` into a readback memory in lockstep with playback. It sits below the AXI register interface, which drives its configuration, memory-write and capture-read ports.

## Interface
- `NUM_SIG`, 8: output/input signal width
- `NUM_SAMP`, 128: pattern and capture depth; AW = $clog2(NUM_SAMP)
- `DIV_W`, 16: hold-divider width
- `REP_W`, 16: repeat-counter width

- `wave_clk` in 1: sole clock
- `wave_rst` in 1: reset, synchronous, active-high
- `start` in 1: single-cycle launch pulse
- `abort` in 1: single-cycle stop pulse
- `mode` in 2: 0 single pass, 1 repeat, 2 continuous, 3 treated as 0
- `loop_len` in AW+1: samples per pass; 0 or >NUM_SAMP means NUM_SAMP
- `repeat_cnt` in REP_W: mode 1 runs repeat_cnt+1 passes
- `clk_div` in DIV_W: each sample is held clk_div+1 cycles
- `idle_val` in NUM_SIG: output value when not running
- `mem_wr_en` in 1, `mem_wr_addr` in AW, `mem_wr_data` in NUM_SIG: pattern memory write port
- `cap_rd_addr` in AW, `cap_rd_data` out NUM_SIG: capture readback port, 1-cycle latency
- `input_signals` in NUM_SIG: DUT response
- `output_signals` out NUM_SIG: registered pattern output
- `busy` out 1, `done` out 1 (1-cycle pulse), `sample_strobe` out 1, `pass_idx` out REP_W

## Operation
- States: IDLE, PRIME, RUN.
- IDLE:
  - `output_signals` <= `idle_val` every cycle.
  - `start` (with `abort` low) moves to PRIME and latches mode, loop_len, repeat_cnt and clk_div.
  - Configuration changes after launch are ignored until the next start.
- PRIME: issues a read of address 0, then moves to RUN.
- RUN:
  - Each sample is held clk_div+1 cycles.
  - The next address is prefetched so consecutive samples have no bubble.
  - At the end of sample loop_len-1, the address wraps to 0 and pass_idx increments.
- Completion:
  - Mode 0 ends after pass 0.
  - Mode 1 ends after pass repeat_cnt.
  - Mode 2 never ends by itself.
  - On completion, at the edge ending the last hold period: output_signals <= idle_val, busy <= 0, done pulses for 1 cycle, state <= IDLE.
- `abort` in PRIME/RUN: next edge goes to IDLE with output <= idle_val; no done pulse.
- `abort` and `start` together in IDLE: abort wins.
- `start` while busy: ignored.
- Capture:
  - On the last cycle of each sample's hold period, `input_signals` is written to capture memory at that sample's address.
  - Later passes overwrite earlier ones.
  - Capture memory is not cleared by reset.
- Pattern writes during RUN are accepted. A write takes effect when that address is next prefetched; no hazard protection.
- `pass_idx` is cleared on start and saturates at all-ones in mode 2.

## Timing
- Reset values: output_signals 0, busy 0, done 0, sample_strobe 0, pass_idx 0, state IDLE. The first edge after reset release loads idle_val.
- Start latency: start sampled at edge k; busy=1 from edge k; output_signals=mem[0] from edge k+2.
- Sample i+1 appears exactly clk_div+1 cycles after sample i, including across the wrap from loop_len-1 to 0.
- `sample_strobe` is high for the one cycle following each output update.
- Single-pass run length (mode 0): output leaves idle for exactly loop_len*(clk_div+1) cycles.
- Abort takes effect at the first edge after it is sampled.

## Structure
- Package `arb_pattern_pkg`: state enum (IDLE/PRIME/RUN) and mode encodings (MODE_SINGLE=0, MODE_REPEAT=1, MODE_CONT=2).
- Sub-module `apg_sdp_ram`: simple dual-port RAM (write port plus 1-cycle registered read), parametrised width/depth. Instantiated twice: pattern memory and capture memory.

## Test plan
- Write mem[0..3]=8'h01,02,04,08; loop_len=4, clk_div=0, mode 0, start -> output 01,02,04,08 on consecutive cycles from start+2, then idle_val; done one pulse; busy high 6 cycles.
- Same pattern, clk_div=2, mode 1, repeat_cnt=1 -> each value held 3 cycles, sequence played twice with no gap at the wrap; pass_idx 0 then 1; single done after 24 output cycles.
- Mode 2, loop_len=2, abort after 9 cycles of RUN -> idle_val at the next edge, busy 0, no done pulse.
- Loopback input_signals=output_signals ^ 8'hFF, mode 0, loop_len=4 -> cap_rd_data at addresses 0..3 = FE,FD,FB,F7.
- loop_len=0 with NUM_SAMP=128, clk_div=0 -> 128 samples played; start pulsed mid-run ignored; start and abort in the same IDLE cycle -> stays IDLE.
- wave_rst asserted mid-RUN -> next edge: output 0, busy 0, state IDLE; a fresh start afterwards replays correctly from mem[0].

Source files
------------

// File: rtl/arb_pattern_pkg.sv
// Shared types for the arbitrary pattern engine: sequencer states and replay modes.
package arb_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_REPEAT = 2'd1;
  localparam logic [1:0] MODE_CONT   = 2'd2;

endpackage

// File: rtl/apg_sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port (1-cycle latency).
module apg_sdp_ram #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/arb_pattern_engine.sv
// Pattern sequencer core: replays pattern memory onto output_signals with programmable
// hold, loop length and repeat mode, capturing input_signals at the end of each sample.
module arb_pattern_engine
  import arb_pattern_pkg::*;
#(
  parameter int  NUM_SIG  = 8,
  parameter int  NUM_SAMP = 128,
  parameter int  DIV_W    = 16,
  parameter int  REP_W    = 16,
  localparam int AW       = $clog2(NUM_SAMP)
) (
  input  logic               wave_clk,
  input  logic               wave_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [AW:0]        loop_len,
  input  logic [REP_W-1:0]   repeat_cnt,
  input  logic [DIV_W-1:0]   clk_div,
  input  logic [NUM_SIG-1:0] idle_val,
  input  logic               mem_wr_en,
  input  logic [AW-1:0]      mem_wr_addr,
  input  logic [NUM_SIG-1:0] mem_wr_data,
  input  logic [AW-1:0]      cap_rd_addr,
  output logic [NUM_SIG-1:0] cap_rd_data,
  input  logic [NUM_SIG-1:0] input_signals,
  output logic [NUM_SIG-1:0] output_signals,
  output logic               busy,
  output logic               done,
  output logic               sample_strobe,
  output logic [REP_W-1:0]   pass_idx,
  output state_e             dbg_state_o
);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [AW-1:0]      len_m1_q, len_m1_d;
  logic [REP_W-1:0]   rep_q, rep_d, pass_q, pass_d;
  logic [DIV_W-1:0]   div_q, div_d, hold_q, hold_d;
  logic [AW-1:0]      ptr_q, ptr_d, cur_q, cur_d;
  logic               valid_q, valid_d;
  logic [NUM_SIG-1:0] out_q, out_d;
  logic               busy_q, busy_d, done_q, done_d, strobe_q, strobe_d;

  logic               launch, load_now, end_of_pass, last_pass, finish;
  logic               pat_rd_en, cap_wr_en;
  logic [AW-1:0]      len_m1_cfg;
  logic [NUM_SIG-1:0] pat_rd_data;

  function automatic logic [AW-1:0] adv(input logic [AW-1:0] a, input logic [AW-1:0] last);
    return (a == last) ? '0 : a + AW'(1);
  endfunction

  always_comb begin
    if (loop_len == '0 || int'(loop_len) > NUM_SAMP) len_m1_cfg = AW'(NUM_SAMP - 1);
    else len_m1_cfg = AW'(loop_len - (AW+1)'(1));
  end

  // ptr_q is the prefetch address; cur_q is the sample currently on the output.
  assign launch      = (state_q == IDLE) && start && !abort;
  assign load_now    = (state_q == RUN) && (hold_q == '0);
  assign end_of_pass = valid_q && (cur_q == len_m1_q);
  assign finish      = load_now && end_of_pass && last_pass;
  assign pat_rd_en   = ((state_q == PRIME) || (load_now && !finish)) && !abort;
  assign cap_wr_en   = load_now && valid_q && !abort;

  always_comb begin
    case (mode_q)
      MODE_REPEAT: last_pass = (pass_q == rep_q);
      MODE_CONT:   last_pass = 1'b0;
      default:     last_pass = 1'b1;
    endcase
  end

  always_ff @(posedge wave_clk) begin
    if (wave_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = PRIME;
      PRIME:   state_d = abort ? IDLE : RUN;
      RUN:     if (abort || finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d   = mode_q;
    len_m1_d = len_m1_q;
    rep_d    = rep_q;
    div_d    = div_q;
    hold_d   = hold_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    valid_d  = valid_q;
    pass_d   = pass_q;
    out_d    = out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    strobe_d = 1'b0;
    case (state_q)
      IDLE: begin
        out_d  = idle_val;
        busy_d = 1'b0;
        if (launch) begin
          mode_d   = mode;
          len_m1_d = len_m1_cfg;
          rep_d    = repeat_cnt;
          div_d    = clk_div;
          busy_d   = 1'b1;
          pass_d   = '0;
          ptr_d    = '0;
          cur_d    = '0;
          valid_d  = 1'b0;
          hold_d   = '0;
        end
      end
      PRIME: begin
        if (abort) begin
          out_d  = idle_val;
          busy_d = 1'b0;
        end else begin
          ptr_d = adv(ptr_q, len_m1_q);
        end
      end
      RUN: begin
        if (abort || finish) begin
          out_d  = idle_val;
          busy_d = 1'b0;
          done_d = !abort;
        end else if (load_now) begin
          out_d    = pat_rd_data;
          strobe_d = 1'b1;
          hold_d   = div_q;
          ptr_d    = adv(ptr_q, len_m1_q);
          cur_d    = valid_q ? adv(cur_q, len_m1_q) : '0;
          valid_d  = 1'b1;
          if (end_of_pass && pass_q != '1) pass_d = pass_q + REP_W'(1);
        end else begin
          hold_d = hold_q - DIV_W'(1);
        end
      end
      default: begin
        out_d  = idle_val;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wave_clk) begin
    if (wave_rst) begin
      mode_q   <= '0;
      len_m1_q <= '0;
      rep_q    <= '0;
      div_q    <= '0;
      hold_q   <= '0;
      ptr_q    <= '0;
      cur_q    <= '0;
      valid_q  <= 1'b0;
      pass_q   <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      len_m1_q <= len_m1_d;
      rep_q    <= rep_d;
      div_q    <= div_d;
      hold_q   <= hold_d;
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      valid_q  <= valid_d;
      pass_q   <= pass_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      strobe_q <= strobe_d;
    end
  end

  apg_sdp_ram #(.WIDTH(NUM_SIG), .DEPTH(NUM_SAMP)) u_pat_mem (
    .clk_i     (wave_clk),
    .wr_en_i   (mem_wr_en),
    .wr_addr_i (mem_wr_addr),
    .wr_data_i (mem_wr_data),
    .rd_en_i   (pat_rd_en),
    .rd_addr_i (ptr_q),
    .rd_data_o (pat_rd_data)
  );

  apg_sdp_ram #(.WIDTH(NUM_SIG), .DEPTH(NUM_SAMP)) u_cap_mem (
    .clk_i     (wave_clk),
    .wr_en_i   (cap_wr_en),
    .wr_addr_i (cur_q),
    .wr_data_i (input_signals),
    .rd_en_i   (1'b1),
    .rd_addr_i (cap_rd_addr),
    .rd_data_o (cap_rd_data)
  );

  assign output_signals = out_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign sample_strobe  = strobe_q;
  assign pass_idx       = pass_q;
  assign dbg_state_o    = state_q;

endmodule
